// File: rtl/add_pipe_n_pkg.sv
// Shared helpers for the segmented pipelined adder: segment sizing and
// carry-into-MSB recovery used for signed overflow detection.
package add_pipe_n_pkg;

    function automatic int seg_width(input int width, input int seg);
        return width / seg;
    endfunction

    // The sum bit is a ^ b ^ carry_in, so the carry into a bit position
    // falls out of its operand bits and its sum bit.
    function automatic logic msb_carry_in(input logic a_msb, input logic b_msb, input logic sum_msb);
        return a_msb ^ b_msb ^ sum_msb;
    endfunction

endpackage

// File: rtl/add_pipe_n_seg.sv
// One registered SW-bit ripple slice of the segmented adder.
// Registers its sum, carry out and the carry that entered its top bit.
module add_seg
    import add_pipe_n_pkg::*;
#(
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [SW-1:0] a,
    input  logic [SW-1:0] b,
    input  logic          cin,
    output logic [SW-1:0] sum,
    output logic          cout,
    output logic          cmsb
);

    logic [SW:0] full_next;
    logic [SW-1:0] sum_reg;
    logic cout_reg;
    logic cmsb_reg;

    assign full_next = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, cin};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            cmsb_reg <= 1'b0;
        end else if (en) begin
            sum_reg  <= full_next[SW-1:0];
            cout_reg <= full_next[SW];
            cmsb_reg <= msb_carry_in(a[SW-1], b[SW-1], full_next[SW-1]);
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign cmsb = cmsb_reg;

endmodule

// File: rtl/add_pipe_n.sv
// Pipelined WIDTH-bit adder/subtractor split into SEG ripple segments, one
// register stage per segment, with valid/ready flow control and carry/overflow flags.
module add_pipe_n
    import add_pipe_n_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int SW = seg_width(WIDTH, SEG);

    if ((WIDTH % SEG) != 0) begin : g_bad_param
        $fatal(1, "add_pipe_n: WIDTH (%0d) must be a multiple of SEG (%0d)", WIDTH, SEG);
    end

    logic             en;
    logic [WIDTH-1:0] b_eff;
    logic             c0;
    logic [SEG-1:0]   vld_reg;

    // Whole pipeline moves as one; it only freezes when a finished result is refused.
    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = in_sub ? ~in_b : in_b;
    assign c0       = in_sub | in_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg <= '0;
        end else if (en) begin
            vld_reg <= (vld_reg << 1) | SEG'(in_valid);
        end
    end

    assign out_valid = vld_reg[SEG-1];

    for (genvar gi = 0; gi < SEG; gi++) begin : stg
        // Operand bits of this stage's beat that are still waiting for their carry.
        localparam int REM = WIDTH - gi * SW;

        logic [REM-1:0] a_src;
        logic [REM-1:0] b_src;
        logic           seg_cin;
        logic [SW-1:0]  seg_sum;
        logic           seg_cout;
        logic           seg_cmsb;

        if (gi == 0) begin : g_src
            assign a_src   = in_a;
            assign b_src   = b_eff;
            assign seg_cin = c0;
        end else begin : g_src
            assign a_src   = stg[gi-1].g_skew.a_rem_reg;
            assign b_src   = stg[gi-1].g_skew.b_rem_reg;
            assign seg_cin = stg[gi-1].seg_cout;
        end

        add_seg #(.SW(SW)) u_seg (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .a     (a_src[SW-1:0]),
            .b     (b_src[SW-1:0]),
            .cin   (seg_cin),
            .sum   (seg_sum),
            .cout  (seg_cout),
            .cmsb  (seg_cmsb)
        );

        if (gi < SEG - 1) begin : g_skew
            logic [REM-SW-1:0] a_rem_reg;
            logic [REM-SW-1:0] b_rem_reg;
            // Only the top segment's MSB carry feeds the overflow flag.
            logic unused_cmsb;
            assign unused_cmsb = seg_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_reg <= '0;
                    b_rem_reg <= '0;
                end else if (en) begin
                    a_rem_reg <= a_src[REM-1:SW];
                    b_rem_reg <= b_src[REM-1:SW];
                end
            end
        end

        if (gi > 0) begin : g_lo
            // Finished lower sum bits travel alongside the beat until the top segment completes.
            logic [gi*SW-1:0] lo_reg;
            logic [gi*SW-1:0] lo_next;

            if (gi == 1) begin : g_n
                assign lo_next = stg[0].seg_sum;
            end else begin : g_n
                assign lo_next = {stg[gi-1].seg_sum, stg[gi-1].g_lo.lo_reg};
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    lo_reg <= '0;
                end else if (en) begin
                    lo_reg <= lo_next;
                end
            end
        end
    end

    if (SEG == 1) begin : g_out
        assign out_sum = stg[0].seg_sum;
    end else begin : g_out
        assign out_sum = {stg[SEG-1].seg_sum, stg[SEG-1].g_lo.lo_reg};
    end

    assign out_cout = stg[SEG-1].seg_cout;
    assign out_ovf  = stg[SEG-1].seg_cout ^ stg[SEG-1].seg_cmsb;

endmodule

// File: tb/tb_add_pipe_n.sv
// Scoreboard bench for add_pipe_n: directed and random beats on a 16/4 instance
// plus random streams on several other WIDTH/SEG instances.
module tb_add_pipe_n;

    localparam int W = 16;
    localparam int S = 4;
    localparam int SWEEP_BEATS = 1000;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rst_sw_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int checks = 0;
    int errors = 0;

    exp_t         q[$];
    int           cyc = 0;
    bit           lat_chk = 1'b0;
    bit           hold_pend = 1'b0;
    logic [W+1:0] held;
    bit           toggle_en = 1'b0;

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(int w, longint unsigned a, longint unsigned b, bit cin, bit sub);
        exp_t e;
        longint unsigned m, ur;
        longint sa, sb, sr, half;
        m    = 64'd1 << w;
        half = longint'(m >> 1);
        sa   = (a >= (m >> 1)) ? longint'(a) - longint'(m) : longint'(a);
        sb   = (b >= (m >> 1)) ? longint'(b) - longint'(m) : longint'(b);
        if (sub) begin
            ur = a + m - b;
            sr = sa - sb;
        end else begin
            ur = a + b + longint'(cin);
            sr = sa + sb + longint'(cin);
        end
        e.sum  = ur % m;
        e.cout = (ur >= m);
        e.ovf  = (sr < -half) || (sr >= half);
        e.cyc  = 0;
        return e;
    endfunction

    function automatic longint unsigned pick(int w);
        longint unsigned m;
        m = (64'd1 << w) - 1;
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return m;
            2:       return 64'd1 << (w - 1);
            3:       return (64'd1 << (w - 1)) - 1;
            default: return {$urandom, $urandom} & m;
        endcase
    endfunction

    function automatic int cfg_w(int i);
        case (i)
            0:       return 6;
            1:       return 6;
            2:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int cfg_s(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    add_pipe_n #(.WIDTH(W), .SEG(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Monitor for the main instance: handshake rule, stall hold, results, latency.
    always @(negedge clk) begin
        if (rst_n) begin
            exp_t e;
            cyc++;
            checks++;
            if (in_ready !== (!out_valid || out_ready)) begin
                errors++;
                $display("FAIL in_ready_en: in_ready=%b required %b", in_ready, !out_valid || out_ready);
            end
            if (hold_pend) begin
                checks++;
                if (out_valid !== 1'b1 || {out_cout, out_ovf, out_sum} !== held) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%b cout/ovf/sum=%h required valid=1 %h",
                             out_valid, {out_cout, out_ovf, out_sum}, held);
                end
            end
            hold_pend = out_valid && !out_ready;
            held      = {out_cout, out_ovf, out_sum};
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL stale_beat: got sum=%h with no beat outstanding, required none", out_sum);
                end else begin
                    e = q.pop_front();
                    if (out_sum !== e.sum[W-1:0] || out_cout !== e.cout || out_ovf !== e.ovf) begin
                        errors++;
                        $display("FAIL result: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                                 out_sum, out_cout, out_ovf, e.sum[W-1:0], e.cout, e.ovf);
                    end else begin
                        $display("beat ok: sum=%h cout=%b ovf=%b", out_sum, out_cout, out_ovf);
                    end
                    if (lat_chk) begin
                        checks++;
                        if (cyc - e.cyc != S) begin
                            errors++;
                            $display("FAIL latency: %0d cycles required %0d", cyc - e.cyc, S);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                e     = model(W, in_a, in_b, in_cin, in_sub);
                e.cyc = cyc;
                q.push_back(e);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) out_ready = ~out_ready;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int n;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=0 required 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d beats outstanding required 0", q.size());
        end
    endtask

    // Random streams with random backpressure on the alternative geometries.
    for (genvar gi = 0; gi < 4; gi++) begin : sw
        localparam int SWW = cfg_w(gi);
        localparam int SWS = cfg_s(gi);

        logic [SWW-1:0] a;
        logic [SWW-1:0] b;
        logic [SWW-1:0] sum;
        logic vin, rdy, vout, ordy, cin, sub, cout, ovf;
        exp_t sq[$];
        int   sent = 0;
        int   got  = 0;
        bit   done = 1'b0;
        bit   acc  = 1'b0;

        add_pipe_n #(.WIDTH(SWW), .SEG(SWS)) u_dut (
            .clk       (clk),
            .rst_n     (rst_sw_n),
            .in_valid  (vin),
            .in_ready  (rdy),
            .in_a      (a),
            .in_b      (b),
            .in_cin    (cin),
            .in_sub    (sub),
            .out_valid (vout),
            .out_ready (ordy),
            .out_sum   (sum),
            .out_cout  (cout),
            .out_ovf   (ovf)
        );

        initial begin
            vin  = 1'b0;
            a    = '0;
            b    = '0;
            cin  = 1'b0;
            sub  = 1'b0;
            ordy = 1'b0;
            wait (rst_sw_n === 1'b1);
            forever begin
                @(posedge clk);
                #1;
                ordy = ($urandom_range(0, 3) != 0);
                if (!vin || acc) begin
                    vin = (sent < SWEEP_BEATS) && ($urandom_range(0, 3) != 0);
                    a   = SWW'(pick(SWW));
                    b   = SWW'(pick(SWW));
                    cin = 1'($urandom_range(0, 1));
                    sub = 1'($urandom_range(0, 1));
                end
            end
        end

        always @(negedge clk) begin
            if (rst_sw_n) begin
                exp_t e;
                acc = vin && rdy;
                if (vout && ordy) begin
                    checks++;
                    if (sq.size() == 0) begin
                        errors++;
                        $display("FAIL sweep_stale w=%0d seg=%0d: sum=%h with no beat outstanding", SWW, SWS, sum);
                    end else begin
                        e = sq.pop_front();
                        if (sum !== e.sum[SWW-1:0] || cout !== e.cout || ovf !== e.ovf) begin
                            errors++;
                            $display("FAIL sweep_result w=%0d seg=%0d: sum=%h cout=%b ovf=%b required sum=%h cout=%b ovf=%b",
                                     SWW, SWS, sum, cout, ovf, e.sum[SWW-1:0], e.cout, e.ovf);
                        end
                    end
                    got++;
                    if (got == SWEEP_BEATS) done = 1'b1;
                end
                if (acc) begin
                    e = model(SWW, a, b, cin, sub);
                    sq.push_back(e);
                    sent++;
                end
            end
        end
    end

    initial begin
        int n;
        rst_n     = 1'b1;
        rst_sw_n  = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        #1;
        rst_n    = 1'b0;
        rst_sw_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b sum=%h cout=%b ovf=%b required all zero",
                     out_valid, out_sum, out_cout, out_ovf);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        rst_sw_n = 1'b1;

        // Directed corner beats, back to back, no stall: latency checked.
        lat_chk = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        repeat (8) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        lat_chk = 1'b0;

        // Backpressure: out_ready toggles every cycle.
        toggle_en = 1'b1;
        repeat (8) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain();
        toggle_en = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Reset with three beats in flight and the head beat stalled at the output.
        out_ready = 1'b0;
        repeat (3) send(W'($urandom), W'($urandom), 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_setup: out_valid=%b required 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== '0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: valid=%b sum=%h cout=%b ovf=%b required all zero",
                     out_valid, out_sum, out_cout, out_ovf);
        end
        q.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_stale: out_valid=%b required 0 at cycle %0d", out_valid, i);
            end
        end
        lat_chk = 1'b1;
        send(16'h1234, 16'h4321, 1'b1, 1'b0);
        send(16'h0000, 16'h0001, 1'b0, 1'b1);
        drain();
        lat_chk = 1'b0;

        n = 0;
        while (!(sw[0].done && sw[1].done && sw[2].done && sw[3].done) && n < 30000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!(sw[0].done && sw[1].done && sw[2].done && sw[3].done)) begin
            errors++;
            $display("FAIL sweep_timeout: results %0d/%0d/%0d/%0d required %0d each",
                     sw[0].got, sw[1].got, sw[2].got, sw[3].got, SWEEP_BEATS);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
